// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame: GMII receive framer.
// Strips preamble/SFD, filters DA, hides FCS, checks CRC and length.

module gmii_rx_frame #(
    parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55,
    parameter int          MIN_LEN   = 64,
    parameter int          MAX_LEN   = 1518
) (
    input  logic        gmii_rx_clk,
    input  logic        sys_rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        frame_done,
    output logic        frame_good,
    output logic        crc_err,
    output logic        len_err,
    output logic        addr_drop,
    output logic [10:0] frame_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
    localparam logic [10:0] CNT_SAT     = 11'h7FF;

    // Reflected CRC32, one byte, LSB first.
    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) begin
                r = (r >> 1) ^ CRC_POLY;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    // Station address byte as it appears on the wire.
    function automatic logic [7:0] mac_byte(input logic [2:0] idx);
        logic [7:0] b;
        unique case (idx)
            3'd0:    b = LOCAL_MAC[47:40];
            3'd1:    b = LOCAL_MAC[39:32];
            3'd2:    b = LOCAL_MAC[31:24];
            3'd3:    b = LOCAL_MAC[23:16];
            3'd4:    b = LOCAL_MAC[15:8];
            3'd5:    b = LOCAL_MAC[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic        start, fin;

    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] dly_q, dly_d;
    logic        loc_q, loc_d;
    logic        bc_q, bc_d;
    logic        drop_q, drop_d;

    logic        ov_q, ov_d;
    logic [7:0]  od_q, od_d;
    logic        sof_q, sof_d;
    logic        done_q, done_d;
    logic        good_q, good_d;
    logic        crc_err_q, crc_err_d;
    logic        len_err_q, len_err_d;
    logic        addr_drop_q, addr_drop_d;
    logic [10:0] len_q, len_d;
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] bad_cnt_q, bad_cnt_d;

    logic        crc_bad;
    logic        len_bad;
    logic        in_data;

    assign crc_bad = (crc_q != CRC_RESIDUE);
    assign len_bad = (cnt_q < MIN_L) || (cnt_q > MAX_L);
    assign in_data = (state_q == DATA) && gmii_rx_dv;

    // Next-state logic: preamble/SFD hunt, data capture, drop until idle.
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        start     = 1'b0;
        fin       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == PRE_BYTE) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end else if (gmii_rxd == PRE_BYTE) begin
                    if (pre_cnt_q == 3'd7) begin
                        state_d = DROP;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 3'd1;
                    end
                end else if (gmii_rxd == SFD_BYTE) begin
                    state_d = DATA;
                    start   = 1'b1;
                end else begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                    fin     = 1'b1;
                end
            end
            DROP: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: CRC, byte count, DA match, 4-byte FCS delay, status.
    always_comb begin
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        dly_d       = dly_q;
        loc_d       = loc_q;
        bc_d        = bc_q;
        drop_d      = drop_q;
        ov_d        = 1'b0;
        od_d        = od_q;
        sof_d       = 1'b0;
        done_d      = 1'b0;
        good_d      = good_q;
        crc_err_d   = crc_err_q;
        len_err_d   = len_err_q;
        addr_drop_d = addr_drop_q;
        len_d       = len_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;

        if (start) begin
            crc_d  = CRC_INIT;
            cnt_d  = 11'd0;
            loc_d  = 1'b1;
            bc_d   = 1'b1;
            drop_d = 1'b0;
        end

        if (in_data) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 11'd1;
            crc_d = crc_byte(crc_q, gmii_rxd);
            dly_d = {dly_q[23:0], gmii_rxd};
            if (cnt_q < 11'd6) begin
                loc_d = loc_q && (gmii_rxd == mac_byte(cnt_q[2:0]));
                bc_d  = bc_q && (gmii_rxd == 8'hFF);
            end
            if (cnt_q == 11'd5) begin
                drop_d = !loc_d && !bc_d;
            end
            if ((cnt_q >= 11'd4) && !drop_d) begin
                ov_d  = 1'b1;
                od_d  = dly_q[31:24];
                sof_d = (cnt_q == 11'd4);
            end
        end

        if (fin) begin
            done_d      = 1'b1;
            len_d       = cnt_q;
            crc_err_d   = crc_bad;
            len_err_d   = len_bad;
            addr_drop_d = drop_q;
            good_d      = !crc_bad && !len_bad && !drop_q;
            if (!crc_bad && !len_bad && !drop_q) begin
                good_cnt_d = good_cnt_q + 16'd1;
            end
            if ((crc_bad || len_bad) && !drop_q) begin
                bad_cnt_d = bad_cnt_q + 16'd1;
            end
        end
    end

    // State register.
    always_ff @(posedge gmii_rx_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            pre_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge gmii_rx_clk) begin
        if (sys_rst) begin
            crc_q       <= 32'd0;
            cnt_q       <= 11'd0;
            dly_q       <= 32'd0;
            loc_q       <= 1'b0;
            bc_q        <= 1'b0;
            drop_q      <= 1'b0;
            ov_q        <= 1'b0;
            od_q        <= 8'd0;
            sof_q       <= 1'b0;
            done_q      <= 1'b0;
            good_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            addr_drop_q <= 1'b0;
            len_q       <= 11'd0;
            good_cnt_q  <= 16'd0;
            bad_cnt_q   <= 16'd0;
        end else begin
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            dly_q       <= dly_d;
            loc_q       <= loc_d;
            bc_q        <= bc_d;
            drop_q      <= drop_d;
            ov_q        <= ov_d;
            od_q        <= od_d;
            sof_q       <= sof_d;
            done_q      <= done_d;
            good_q      <= good_d;
            crc_err_q   <= crc_err_d;
            len_err_q   <= len_err_d;
            addr_drop_q <= addr_drop_d;
            len_q       <= len_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    assign out_valid  = ov_q;
    assign out_data   = od_q;
    assign out_sof    = sof_q;
    assign frame_done = done_q;
    assign frame_good = good_q;
    assign crc_err    = crc_err_q;
    assign len_err    = len_err_q;
    assign addr_drop  = addr_drop_q;
    assign frame_len  = len_q;
    assign good_cnt   = good_cnt_q;
    assign bad_cnt    = bad_cnt_q;

endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb_gmii_rx_frame: randomized frames against a frame-level model.
// Checks output stream, frame status and counters at idle checkpoints.

module tb_gmii_rx_frame;

    localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv;
    logic [7:0]  rxd;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        frame_done;
    logic        frame_good;
    logic        crc_err;
    logic        len_err;
    logic        addr_drop;
    logic [10:0] frame_len;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    gmii_rx_frame #(
        .LOCAL_MAC(MAC),
        .MIN_LEN  (64),
        .MAX_LEN  (1518)
    ) dut (
        .gmii_rx_clk(clk),
        .sys_rst    (rst),
        .gmii_rx_dv (dv),
        .gmii_rxd   (rxd),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .frame_done (frame_done),
        .frame_good (frame_good),
        .crc_err    (crc_err),
        .len_err    (len_err),
        .addr_drop  (addr_drop),
        .frame_len  (frame_len),
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
    );

    always #4 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0]  got_q[$];
    int          got_done = 0;
    int          got_base = 0;
    int          done_base = 0;

    logic [8:0]  exp_q[$];
    int          exp_done = 0;
    logic [7:0]  pre_q[$];
    logic [7:0]  frm_q[$];
    logic [10:0] e_len;
    logic        e_crc, e_lerr, e_addr, e_good;
    logic [15:0] e_gcnt, e_bcnt;

    // Collect emitted bytes and frame_done pulses.
    always @(negedge clk) begin
        if (out_valid === 1'b1) got_q.push_back({out_sof, out_data});
        if (frame_done === 1'b1) got_done++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fcs_of(input int len);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ frm_q[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
                else c = c >> 1;
            end
        end
        return ~c;
    endfunction

    function automatic bit pre_ok();
        int n;
        n = pre_q.size();
        if (n < 2 || n > 8) return 1'b0;
        if (pre_q[n-1] != 8'hD5) return 1'b0;
        for (int i = 0; i < n - 1; i++) begin
            if (pre_q[i] != 8'h55) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic set_pre(input int kind);
        int c;
        pre_q.delete();
        case (kind)
            0: c = 7;
            1: begin pre_q.push_back(8'h00); c = 7; end
            2: c = 9;
            3: c = 1;
            4: c = $urandom_range(7, 1);
            5: c = 8;
            default: begin pre_q.push_back(8'h55); c = 1; end
        endcase
        for (int i = 0; i < c; i++) pre_q.push_back(8'h55);
        if (kind == 6) pre_q.push_back(8'h12);
        pre_q.push_back(8'hD5);
    endtask

    task automatic build(input int n, input int kind, input bit corrupt);
        logic [47:0] da;
        logic [31:0] f;
        int          idx;
        case (kind)
            0: da = MAC;
            1: da = '1;
            2: da = 48'h02_00_00_00_00_01;
            3: da = {MAC[47:8], 8'h56};
            default: da = {8'h02, 8'($urandom), 32'($urandom)};
        endcase
        frm_q.delete();
        for (int i = 0; i < n - 4; i++) begin
            if (i < 6) frm_q.push_back(da[47-8*i -: 8]);
            else frm_q.push_back(8'($urandom));
        end
        f = fcs_of(n - 4);
        frm_q.push_back(f[7:0]);
        frm_q.push_back(f[15:8]);
        frm_q.push_back(f[23:16]);
        frm_q.push_back(f[31:24]);
        if (corrupt && n >= 5) begin
            idx = $urandom_range(n - 5, 0);
            frm_q[idx] = frm_q[idx] ^ (8'h01 << $urandom_range(7, 0));
        end
    endtask

    task automatic model_frame(input bit corrupt);
        int          n;
        bit          ok;
        logic [47:0] da;
        if (!pre_ok()) return;
        n  = frm_q.size();
        ok = 1'b1;
        if (n >= 6) begin
            da = {frm_q[0], frm_q[1], frm_q[2], frm_q[3], frm_q[4], frm_q[5]};
            ok = (da == MAC) || (da == 48'hFFFF_FFFF_FFFF);
        end
        if (n >= 5) begin
            if (ok) begin
                for (int i = 0; i <= n - 5; i++) exp_q.push_back({i == 0, frm_q[i]});
            end else begin
                exp_q.push_back({1'b1, frm_q[0]});
            end
        end
        exp_done++;
        e_len  = (n > 2047) ? 11'd2047 : 11'(n);
        e_crc  = corrupt;
        e_lerr = (n < 64) || (n > 1518);
        e_addr = !ok;
        e_good = !e_crc && !e_lerr && !e_addr;
        if (e_good) e_gcnt++;
        if ((e_crc || e_lerr) && !e_addr) e_bcnt++;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_done  = 0;
        got_base  = got_q.size();
        done_base = got_done;
        e_len = '0; e_crc = 0; e_lerr = 0; e_addr = 0; e_good = 0;
        e_gcnt = '0; e_bcnt = '0;
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'(0));
        chk({tag, ".done"}, 64'(frame_done), 64'(0));
        chk({tag, ".len"}, 64'(frame_len), 64'(0));
        chk({tag, ".good"}, 64'(frame_good), 64'(0));
        chk({tag, ".gcnt"}, 64'(good_cnt), 64'(0));
        chk({tag, ".bcnt"}, 64'(bad_cnt), 64'(0));
    endtask

    task automatic send(input int gap, input int rst_at);
        foreach (pre_q[i]) begin
            @(negedge clk);
            dv = 1'b1; rxd = pre_q[i];
        end
        for (int i = 0; i < frm_q.size(); i++) begin
            @(negedge clk);
            if (rst_at >= 0 && i == rst_at + 1) begin
                reset_outputs("midrst");
                model_reset();
            end
            dv = 1'b1; rxd = frm_q[i]; rst = (i == rst_at);
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            dv = 1'b0; rxd = 8'h00; rst = 1'b0;
        end
    endtask

    task automatic checkpoint(input string tag);
        int ng, nbad;
        repeat (3) @(negedge clk);
        #1;
        ng = got_q.size() - got_base;
        chk({tag, ".nbytes"}, 64'(ng), 64'(exp_q.size()));
        nbad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= ng) nbad++;
            else if (got_q[got_base+i] !== exp_q[i]) nbad++;
        end
        chk({tag, ".badbytes"}, 64'(nbad), 64'(0));
        chk({tag, ".ndone"}, 64'(got_done - done_base), 64'(exp_done));
        chk({tag, ".len"}, 64'(frame_len), 64'(e_len));
        chk({tag, ".crc"}, 64'(crc_err), 64'(e_crc));
        chk({tag, ".lerr"}, 64'(len_err), 64'(e_lerr));
        chk({tag, ".addr"}, 64'(addr_drop), 64'(e_addr));
        chk({tag, ".good"}, 64'(frame_good), 64'(e_good));
        chk({tag, ".gcnt"}, 64'(good_cnt), 64'(e_gcnt));
        chk({tag, ".bcnt"}, 64'(bad_cnt), 64'(e_bcnt));
        got_base  = got_q.size();
        done_base = got_done;
        exp_q.delete();
        exp_done = 0;
    endtask

    task automatic frame(input string tag, input int n, input int kind,
                         input bit corr);
        build(n, kind, corr);
        model_frame(corr);
        send(1, -1);
        checkpoint(tag);
    endtask

    initial begin
        int n, sel, pk;
        bit corr;
        rst = 1'b1; dv = 1'b0; rxd = 8'h00;
        repeat (4) @(negedge clk);
        model_reset();
        reset_outputs("reset");
        chk("reset.sof", 64'(out_sof), 64'(0));
        chk("reset.data", 64'(out_data), 64'(0));
        chk("reset.crc", 64'(crc_err), 64'(0));
        chk("reset.lerr", 64'(len_err), 64'(0));
        chk("reset.addr", 64'(addr_drop), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        set_pre(0);
        frame("uni64", 64, 0, 0);
        frm_q[30] = frm_q[30] ^ 8'h04;
        model_frame(1);
        send(1, -1);
        checkpoint("crc64");
        frame("bcast100", 100, 1, 0);
        frame("other64", 64, 2, 0);
        frame("near64", 64, 3, 0);
        frame("len40", 40, 0, 0);
        frame("len1518", 1518, 0, 0);
        frame("len1600", 1600, 1, 0);
        frame("len2100", 2100, 0, 0);
        frame("len4", 4, 0, 0);
        frame("len5", 5, 0, 0);
        frame("len63", 63, 0, 0);

        set_pre(1); frame("pre00", 64, 0, 0);
        set_pre(2); frame("pre9", 64, 0, 0);
        set_pre(5); frame("pre8", 64, 0, 0);
        set_pre(6); frame("prebad", 64, 0, 0);
        set_pre(3); frame("pre1", 64, 0, 0);

        set_pre(0);
        build(64, 0, 0); model_frame(0); send(1, -1);
        build(80, 1, 0); model_frame(0); send(1, -1);
        checkpoint("b2b");

        build(100, 0, 0);
        frm_q[45] = 8'h00;
        send(1, 44);
        checkpoint("rstframe");
        frame("afterrst", 64, 0, 0);

        for (int t = 0; t < 16; t++) begin
            pk = $urandom_range(9, 0);
            if (pk < 6) set_pre(0);
            else if (pk < 8) set_pre(4);
            else if (pk == 8) set_pre(3);
            else set_pre($urandom_range(1, 0) == 0 ? 2 : 6);
            sel = $urandom_range(3, 0);
            case (sel)
                0: n = $urandom_range(12, 4);
                1: n = $urandom_range(68, 60);
                2: n = $urandom_range(300, 13);
                default: n = $urandom_range(1525, 1510);
            endcase
            corr = ($urandom_range(3, 0) == 0) && (n >= 5);
            build(n, $urandom_range(4, 0), corr);
            model_frame(corr);
            send($urandom_range(3, 1), -1);
            checkpoint($sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
